efpga_top: RTL and testbench

Golden user design for the eFPGA's 31-bit user I/O ring. The eFPGA fabric is loaded with a bitstream that implements this function, and its pad outputs and output enables must match this block cycle-for-cycle. The function is a 28-bit up/down counter with hold, and it drives a fixed I/O direction pattern. The block is pure synchronous logic on one clock and has no configuration interface.

---
 rtl/efpga_top_pkg.sv | 17 +
 rtl/updown_counter.sv | 29 ++
 rtl/efpga_top.sv | 39 +++
 tb/tb_efpga_top.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/efpga_top_pkg.sv
// Shared constants for the eFPGA golden user design: pad widths, pad
// index map and the fixed output-enable pattern of the user I/O ring.
package efpga_top_pkg;

  localparam int IO_W     = 31;
  localparam int CNT_W    = 28;

  // Pad index map: the three low pads are control inputs, the rest carry count.
  localparam int RST_IDX  = 0;
  localparam int DIR_IDX  = 1;
  localparam int HOLD_IDX = 2;
  localparam int OUT_LSB  = 3;

  // Active-low output enables: low three pads are inputs, upper pads drive.
  localparam logic [IO_W-1:0] OEB_PATTERN = 31'h0000_0007;

endpackage

// File: rtl/updown_counter.sv
// Up/down counter with hold and synchronous active-high reset.
// Priority per edge: reset, then hold, then count in the selected direction.
// Wraps modulo 2^CNT_W in both directions with no flags.
module updown_counter #(
  parameter int CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             dir,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Count register: reset wins, hold freezes, dir=1 counts down.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      if (dir) begin
        q <= q - CNT_ONE;
      end else begin
        q <= q + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/efpga_top.sv
// eFPGA golden user design: pad mapping around a 28-bit up/down counter.
// io_in[0]=rst, io_in[1]=dir, io_in[2]=hold; io_in[30:3] are ignored.
// io_out carries the registered count in its upper pads; low pads read 0.
// io_oeb is a constant direction pattern, independent of clock and reset.
module efpga_top
  import efpga_top_pkg::*;
#(
  parameter int CNT_W = efpga_top_pkg::CNT_W,
  parameter int IO_W  = efpga_top_pkg::IO_W
) (
  input  logic            clk,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb
);

  logic [CNT_W-1:0] count;
  logic             unused_pads;

  // Upper input pads have no function; fold them so they are visibly consumed.
  assign unused_pads = ^io_in[IO_W-1:OUT_LSB];

  updown_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk  (clk),
    .rst  (io_in[RST_IDX]),
    .hold (io_in[HOLD_IDX]),
    .dir  (io_in[DIR_IDX]),
    .q    (count)
  );

  // Count drives the output pads straight from the register; control pads read 0.
  assign io_out = {count, {OUT_LSB{1'b0}}};

  // Fixed direction pattern for the ring.
  assign io_oeb = OEB_PATTERN;

endmodule

// File: tb/tb_efpga_top.sv
// Bench for efpga_top: directed vector table, hand-written test-plan
// sequences, and randomized stimulus scored against a modular-arithmetic
// reference model through an expected-value queue.
module tb_efpga_top;

  localparam int    IO_W = 31;
  localparam int    CNT_W = 28;
  localparam longint MOD = 64'd268435456;

  logic            clk;
  logic [IO_W-1:0] io_in;
  logic [IO_W-1:0] io_out;
  logic [IO_W-1:0] io_oeb;

  int n_tests;
  int n_fail;

  logic [CNT_W-1:0] model_cnt;
  logic [CNT_W-1:0] exp_q[$];

  efpga_top dut (
    .clk    (clk),
    .io_in  (io_in),
    .io_out (io_out),
    .io_oeb (io_oeb)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [IO_W-1:0] act,
                       input logic [IO_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour: reset clears, hold keeps, dir selects +1/-1 mod 2^28.
  function automatic logic [CNT_W-1:0] model_next(input logic [CNT_W-1:0] c,
                                                  input logic [IO_W-1:0] v);
    longint m;
    if (v[0]) return '0;
    if (v[2]) return c;
    m = longint'(c);
    m = v[1] ? m - 1 : m + 1;
    m = (m + MOD) % MOD;
    return m[CNT_W-1:0];
  endfunction

  // ---------------- driver task ----------------
  // Applies one input word for one edge, scores io_out/io_oeb against the model.
  task automatic drive(input logic [IO_W-1:0] v, input string name);
    logic [CNT_W-1:0] e;
    io_in = v;
    model_cnt = model_next(model_cnt, v);
    exp_q.push_back(model_cnt);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({name, "/model"}, io_out, {e, 3'b000});
    check({name, "/oeb"}, io_oeb, 31'h0000_0007);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) drive(31'h1, "reset");
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [IO_W-1:0]  in;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  // ---------------- main test ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_cnt = '0;
    io_in = 31'h1;
    @(posedge clk);
    #1;

    // Directed table: reset, count, hold, down-wrap, up-wrap, reset priority.
    vecs.push_back('{31'h1,        28'h0});
    vecs.push_back('{31'h1,        28'h0});
    vecs.push_back('{31'h0,        28'h1});
    vecs.push_back('{31'h0,        28'h2});
    vecs.push_back('{31'h4,        28'h2});
    vecs.push_back('{31'h6,        28'h2});
    vecs.push_back('{31'h2,        28'h1});
    vecs.push_back('{31'h2,        28'h0});
    vecs.push_back('{31'h2,        28'hFFF_FFFF});
    vecs.push_back('{31'h2,        28'hFFF_FFFE});
    vecs.push_back('{31'h0,        28'hFFF_FFFF});
    vecs.push_back('{31'h0,        28'h0});
    vecs.push_back('{31'h0,        28'h1});
    vecs.push_back('{31'h7,        28'h0});
    vecs.push_back('{31'h6,        28'h0});
    vecs.push_back('{31'h0,        28'h1});
    vecs.push_back('{31'h3,        28'h0});
    vecs.push_back('{31'h2,        28'hFFF_FFFF});
    vecs.push_back('{31'h5,        28'h0});
    vecs.push_back('{31'h7FFF_FFF8, 28'h1});
    vecs.push_back('{31'h5555_5552, 28'h0});
    vecs.push_back('{31'h2AAA_AAAC, 28'h0});
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in, $sformatf("vec%0d", i));
      check($sformatf("vec%0d/table", i), io_out, {vecs[i].exp_cnt, 3'b000});
    end

    // Reset then count for 100 cycles: io_out = k<<3.
    do_reset(5);
    check("rst_then_count/zero", io_out, 31'h0);
    for (int k = 1; k <= 100; k++) begin
      drive(31'h0, "count");
      check($sformatf("count_k%0d", k), io_out, IO_W'(k) << 3);
    end

    // Hold at count 5 for three cycles, then resume at 6.
    do_reset(1);
    for (int k = 1; k <= 5; k++) drive(31'h0, "pre_hold");
    for (int i = 0; i < 3; i++) begin
      drive(31'h4, "hold");
      check($sformatf("hold_c%0d", i), io_out, 31'h28);
    end
    drive(31'h0, "resume");
    check("hold_resume", io_out, 31'h30);

    // Reset priority mid-count, then hold keeps zero.
    drive(31'h7, "rst_prio");
    check("rst_prio_zero", io_out, 31'h0);
    drive(31'h6, "hold_after_rst");
    check("hold_after_rst_zero", io_out, 31'h0);

    // Ignored upper pads toggled randomly while counting from reset.
    do_reset(5);
    for (int k = 1; k <= 100; k++) begin
      logic [IO_W-1:0] noise;
      noise = IO_W'($urandom) & 31'h7FFF_FFF8;
      drive(noise, "ignored");
      check($sformatf("ignored_k%0d", k), io_out, IO_W'(k) << 3);
    end

    // Randomized run scored against the reference model.
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      logic [IO_W-1:0] v;
      v = IO_W'($urandom) & 31'h7FFF_FFF8;
      v[0] = ($urandom_range(0, 49) == 0);
      v[1] = ($urandom_range(0, 3) != 0) ? (i >= 1500) : ~(i >= 1500);
      v[2] = ($urandom_range(0, 5) == 0);
      drive(v, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
